// File: rtl/i2c_ioexp_pkg.sv
// i2c_ioexp_pkg: shared types for the IO-expander word arbiter
package i2c_ioexp_pkg;
   localparam int IOEXP_WIDTH = 16;
   typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant among N requesters, pointer moves past each winner
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant_onehot,
   output logic [IW-1:0] grant_idx
);
   logic [IW-1:0] ptr;
   logic [IW-1:0] idx;
   logic          found;
   // first active requester at or after the pointer, scanning with wrap-around
   always_comb begin
      grant_idx = '0;
      idx = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            grant_idx = idx;
            found = 1'b1;
         end
      end
      grant_onehot = found ? N'(1) << grant_idx : '0;
   end
   // pointer steps to the requester after the winner whenever a grant is taken
   always_ff @(posedge clk)
      if (reset) ptr <= '0;
      else if (advance) ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/i2c_ioexp_arb.sv
// i2c_ioexp_arb: merges masked requester writes into the shared IO-expander word with a post-change hold
module i2c_ioexp_arb
   import i2c_ioexp_pkg::*;
#(
   parameter int               NUM_REQ     = 4,
   parameter int               WIDTH       = IOEXP_WIDTH,
   parameter int               HOLD_CYCLES = 65536,
   parameter logic [WIDTH-1:0] RESET_WORD  = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] wr_mask,
   input  logic [NUM_REQ*WIDTH-1:0] wr_data,
   output logic [NUM_REQ-1:0]       ack,
   output logic [WIDTH-1:0]         out,
   output logic                     upd,
   output logic                     busy
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(HOLD_CYCLES + 1);

   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic [NUM_REQ-1:0] g_oh;
   logic [IW-1:0]      g_idx;
   logic               advance;
   logic [WIDTH-1:0]   mask_g, data_g, new_word;

   assign advance  = (state == IDLE) && |req;
   assign mask_g   = wr_mask[g_idx*WIDTH +: WIDTH];
   assign data_g   = wr_data[g_idx*WIDTH +: WIDTH];
   assign new_word = (out & ~mask_g) | (data_g & mask_g);
   assign busy     = state != IDLE;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .advance      (advance),
      .grant_onehot (g_oh),
      .grant_idx    (g_idx)
   );

   // state register
   always_ff @(posedge clk) state <= reset ? IDLE : state_nx;

   // ACK lasts one cycle; HOLD follows only when the word actually changed (upd is high in ACK)
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (advance) state_nx = ACK;
         ACK:     state_nx = upd ? HOLD : IDLE;
         HOLD:    if (cnt == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // output word, ack/upd pulses and hold countdown, all registered at the granting edge
   always_ff @(posedge clk) begin
      if (reset) begin
         out <= RESET_WORD;
         ack <= '0;
         upd <= 1'b0;
         cnt <= '0;
      end else begin
         ack <= advance ? g_oh : '0;
         upd <= advance && (new_word != out);
         if (advance) out <= new_word;
         if (state == ACK) cnt <= CW'(HOLD_CYCLES - 1);
         else if (state == HOLD && cnt != '0) cnt <= cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_i2c_ioexp_arb.sv
// tb_i2c_ioexp_arb: randomized and directed checks of the IO-expander arbiter against a transaction model
module tb_i2c_ioexp_arb;
   localparam int N = 4;
   localparam int W = 16;
   localparam int HOLD = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] wr_mask, wr_data;
   logic [N-1:0]   ack;
   logic [W-1:0]   out;
   logic           upd, busy;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] m_out = '0;
   logic [N-1:0] m_ack = '0;
   logic         m_upd = 1'b0;
   logic         m_busy = 1'b0;
   int           m_ptr = 0;
   int           free_edge = 0;
   int           busy_last = -1;
   int           edge_n = 0;
   bit           hold_req = 1'b0;
   int           dut_ack_edge[N] = '{default: -1};
   int           busy_run = 0;
   int           last_run = 0;

   always #5 clk = ~clk;

   i2c_ioexp_arb #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(HOLD), .RESET_WORD(16'h0000)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .wr_mask (wr_mask),
      .wr_data (wr_data),
      .ack     (ack),
      .out     (out),
      .upd     (upd),
      .busy    (busy)
   );

   task automatic present(input int i, input logic [W-1:0] mk, input logic [W-1:0] dt);
      wr_mask[i*W +: W] = mk;
      wr_data[i*W +: W] = dt;
      req[i] = 1'b1;
   endtask

   // disjoint nibble per requester and data inverting it, so every write changes the word
   task automatic present_rr(input int i);
      logic [W-1:0] mk;
      mk = W'($urandom_range(1, 15)) << (4 * i);
      present(i, mk, (~m_out & mk) | (W'($urandom) & ~mk));
   endtask

   // one clock: the model decides this edge's grant from the rules, then outputs are sampled 1ns later
   task automatic tick();
      int g;
      logic [W-1:0] mk, dt, nw;
      @(posedge clk);
      edge_n++;
      m_ack = '0;
      m_upd = 1'b0;
      g = -1;
      if (reset) begin
         m_out = 16'h0000;
         m_ptr = 0;
         free_edge = edge_n + 1;
         busy_last = -1;
      end else if (edge_n >= free_edge && req != '0) begin
         for (int k = 0; k < N; k++)
            if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         mk = wr_mask[g*W +: W];
         dt = wr_data[g*W +: W];
         nw = (m_out & ~mk) | (dt & mk);
         m_upd = nw != m_out;
         m_out = nw;
         m_ack[g] = 1'b1;
         m_ptr = (g + 1) % N;
         free_edge = edge_n + (m_upd ? HOLD + 2 : 2);
         busy_last = edge_n + (m_upd ? HOLD : 0);
      end
      m_busy = edge_n <= busy_last;
      #1;
      for (int i = 0; i < N; i++) if (ack[i] === 1'b1) dut_ack_edge[i] = edge_n;
      if (busy === 1'b1) busy_run++;
      else begin
         if (busy_run != 0) last_run = busy_run;
         busy_run = 0;
      end
      if (g >= 0) begin
         if (hold_req) present_rr(g);
         else req[g] = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (4) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL reset edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      checks++;
      if (out !== 16'h0000 || busy !== 1'b0 || ack !== 4'b0000 || upd !== 1'b0) begin
         failures++;
         $display("FAIL reset_values out=%h busy=%b ack=%b upd=%b exp 0000/0/0000/0", out, busy, ack, upd);
      end
      reset = 1'b0;
      repeat (3) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL idle edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
   endtask

   task automatic test_single();
      int e0;
      e0 = edge_n;
      present(0, 16'hFF00, 16'hAA55);
      repeat (3) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL single edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      checks++;
      if (dut_ack_edge[0] !== e0 + 1 || out !== 16'hAA00) begin
         failures++;
         $display("FAIL single_latency ack_edge=%0d exp %0d out=%h exp aa00", dut_ack_edge[0], e0 + 1, out);
      end
   endtask

   task automatic test_merge();
      present(1, 16'h00FF, 16'h1234);
      repeat (40) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL merge edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      checks++;
      if (dut_ack_edge[1] - dut_ack_edge[0] !== HOLD + 2 || out !== 16'hAA34) begin
         failures++;
         $display("FAIL merge_after_hold gap=%0d exp %0d out=%h exp aa34", dut_ack_edge[1] - dut_ack_edge[0], HOLD + 2, out);
      end
   endtask

   task automatic test_no_change();
      logic upd2;
      upd2 = 1'bx;
      present(2, 16'hFF00, 16'hAA00);
      present(3, 16'h000F, 16'h0007);
      repeat (25) begin
         tick();
         if (ack[2] === 1'b1) upd2 = upd;
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL no_change edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      checks++;
      if (upd2 !== 1'b0 || dut_ack_edge[3] - dut_ack_edge[2] !== 2 || out !== 16'hAA37) begin
         failures++;
         $display("FAIL no_change_timing upd=%b exp 0 gap=%0d exp 2 out=%h exp aa37", upd2, dut_ack_edge[3] - dut_ack_edge[2], out);
      end
   endtask

   task automatic test_round_robin();
      int q[$];
      int eq[$];
      int exp_o[5] = '{0, 1, 2, 3, 0};
      hold_req = 1'b1;
      for (int i = 0; i < N; i++) present_rr(i);
      repeat (5 * (HOLD + 2) + 4) begin
         tick();
         for (int i = 0; i < N; i++)
            if (ack[i] === 1'b1) begin
               q.push_back(i);
               eq.push_back(edge_n);
            end
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL round_robin edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      hold_req = 1'b0;
      req = '0;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (q.size() <= k) begin
            failures++;
            $display("FAIL rr_order grant %0d missing, exp requester %0d", k, exp_o[k]);
         end else if (q[k] !== exp_o[k]) begin
            failures++;
            $display("FAIL rr_order grant %0d got requester %0d exp %0d", k, q[k], exp_o[k]);
         end
      end
      for (int k = 1; k < 5 && k < eq.size(); k++) begin
         checks++;
         if (eq[k] - eq[k-1] !== HOLD + 2) begin
            failures++;
            $display("FAIL rr_spacing grant %0d gap=%0d exp %0d", k, eq[k] - eq[k-1], HOLD + 2);
         end
      end
   endtask

   task automatic test_mask_zero();
      int e0;
      logic [W-1:0] w;
      repeat (20) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL drain edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      w = m_out;
      e0 = edge_n;
      present(0, 16'h0000, 16'hFFFF);
      repeat (4) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL mask_zero edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      checks++;
      if (dut_ack_edge[0] !== e0 + 1 || out !== w) begin
         failures++;
         $display("FAIL mask_zero_word ack_edge=%0d exp %0d out=%h exp %h", dut_ack_edge[0], e0 + 1, out, w);
      end
   endtask

   task automatic test_overlap();
      present(0, 16'h00F0, 16'h0050);
      repeat (3) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL overlap edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      present(1, 16'h0030, 16'h0020);
      repeat (HOLD + 25) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL overlap edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      checks++;
      if (out[7:4] !== 4'b0110 || last_run !== HOLD + 1) begin
         failures++;
         $display("FAIL overlap_bits out[7:4]=%b exp 0110 busy_run=%0d exp %0d", out[7:4], last_run, HOLD + 1);
      end
   endtask

   task automatic test_random();
      repeat (400) begin
         for (int i = 0; i < N; i++)
            if (!req[i] && $urandom_range(0, 7) == 0)
               present(i, ($urandom_range(0, 3) == 0) ? '0 : W'($urandom), W'($urandom));
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL random edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      req = '0;
   endtask

   task automatic test_reset_mid_hold();
      repeat (20) tick();
      present(0, 16'hFFFF, ~m_out);
      repeat (5) begin
         tick();
         checks++;
         if (ack !== m_ack || out !== m_out || upd !== m_upd || busy !== m_busy) begin
            failures++;
            $display("FAIL pre_reset edge=%0d ack=%b exp %b out=%h exp %h upd=%b exp %b busy=%b exp %b", edge_n, ack, m_ack, out, m_out, upd, m_upd, busy, m_busy);
         end
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL hold_entry busy=%b exp 1", busy);
      end
      present(1, 16'h00FF, 16'h0012);
      reset = 1'b1;
      req = '0;
      repeat (10) begin
         tick();
         checks++;
         if (out !== 16'h0000 || busy !== 1'b0 || ack !== 4'b0000 || out !== m_out) begin
            failures++;
            $display("FAIL mid_reset edge=%0d out=%h busy=%b ack=%b exp 0000/0/0000", edge_n, out, busy, ack);
         end
      end
      reset = 1'b0;
      repeat (20) begin
         tick();
         checks++;
         if (ack !== 4'b0000 || busy !== 1'b0 || out !== 16'h0000) begin
            failures++;
            $display("FAIL stale_ack edge=%0d ack=%b busy=%b out=%h exp 0000/0/0000", edge_n, ack, busy, out);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      req = '0;
      wr_mask = '0;
      wr_data = '0;
      test_reset();
      test_single();
      test_merge();
      test_no_change();
      test_round_robin();
      test_mask_zero();
      test_overlap();
      test_random();
      test_reset_mid_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
